// File: rtl/sampler_tag_table_ctrl_pkg.sv
// Shared sampler package: op encodings, FSM state type, table geometry
// and small bit-vector helpers used by the tag table controller.
package sampler_tag_table_ctrl_pkg;
  localparam int unsigned NUM_ENT = 16;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned OCC_W   = 5;

  typedef enum logic [1:0] {
    OP_LOOKUP       = 2'b00,
    OP_LOOKUP_ALLOC = 2'b01,
    OP_INVAL        = 2'b10,
    OP_FLUSH        = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MATCH,
    ST_DECIDE,
    ST_RESP,
    ST_FLUSH
  } state_e;

  function automatic logic [OCC_W-1:0] popcount(input logic [NUM_ENT-1:0] v);
    logic [OCC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_ENT; i++) cnt = cnt + OCC_W'(v[i]);
    return cnt;
  endfunction

  // Lowest-index clear bit; result is meaningless when v is all ones.
  function automatic logic [IDX_W-1:0] first_zero(input logic [NUM_ENT-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_ENT - 1; i >= 0; i--) if (!v[i]) idx = IDX_W'(i);
    return idx;
  endfunction
endpackage

// File: rtl/sampler_tag_table_ctrl_enc.sv
// One-hot to index encoder for the registered match vector; relies on at
// most one bit being set, which the allocator guarantees.
module tag_match_encoder_4b
  import sampler_tag_table_ctrl_pkg::*;
(
  input  logic [NUM_ENT-1:0] match_i,
  output logic               hit_o,
  output logic [IDX_W-1:0]   index_o
);
  always_comb begin
    index_o = '0;
    for (int i = 0; i < NUM_ENT; i++) if (match_i[i]) index_o = index_o | IDX_W'(i);
  end

  assign hit_o = |match_i;
endmodule

// File: rtl/sampler_tag_table_ctrl.sv
// 16-entry fully associative tag table with lookup, lookup-allocate
// (lowest free slot, else round-robin victim), invalidate and serial flush.
module sampler_tag_table_ctrl
  import sampler_tag_table_ctrl_pkg::*;
#(
  parameter int unsigned TAG_W = 26
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic [3:0]       req_index_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_hit_o,
  output logic [3:0]       rsp_index_o,
  output logic             rsp_alloc_o,
  output logic             rsp_evict_o,
  output logic [TAG_W-1:0] rsp_evict_tag_o,
  output logic [4:0]       occupancy_o
);
  state_e                         state_q;
  op_e                            op_q;
  logic [TAG_W-1:0]               tag_q;
  logic [NUM_ENT-1:0]             match_q, match_d;
  logic [NUM_ENT-1:0]             valid_q, valid_d;
  logic [NUM_ENT-1:0][TAG_W-1:0]  tags_q;
  logic [IDX_W-1:0]               ptr_q, flush_idx_q;
  logic [OCC_W-1:0]               occ_q;
  logic                           rsp_valid_q, rsp_hit_q, rsp_alloc_q, rsp_evict_q;
  logic [IDX_W-1:0]               rsp_index_q;
  logic [TAG_W-1:0]               rsp_evict_tag_q;

  logic             enc_hit;
  logic [IDX_W-1:0] enc_idx;
  logic             has_free, alloc_now;
  logic [IDX_W-1:0] alloc_idx;
  op_e              req_op;

  tag_match_encoder_4b u_enc (
    .match_i (match_q),
    .hit_o   (enc_hit),
    .index_o (enc_idx)
  );

  assign req_op    = op_e'(req_op_i);
  assign has_free  = ~&valid_q;
  assign alloc_idx = has_free ? first_zero(valid_q) : ptr_q;
  assign alloc_now = (state_q == ST_DECIDE) && !enc_hit && (op_q == OP_LOOKUP_ALLOC);

  always_comb begin
    for (int i = 0; i < NUM_ENT; i++) match_d[i] = valid_q[i] && (tags_q[i] == tag_q);
  end

  // Every valid-bit change funnels through here so occupancy tracks it exactly.
  always_comb begin
    valid_d = valid_q;
    case (state_q)
      ST_IDLE:   if (req_valid_i && req_op == OP_INVAL) valid_d[req_index_i] = 1'b0;
      ST_DECIDE: if (alloc_now) valid_d[alloc_idx] = 1'b1;
      ST_FLUSH:  valid_d[flush_idx_q] = 1'b0;
      default:   ;
    endcase
  end

  // Tag storage is never reset; an entry's tag only matters while valid.
  always_ff @(posedge clock_i) begin
    if (alloc_now) tags_q[alloc_idx] <= tag_q;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q         <= ST_IDLE;
      op_q            <= OP_LOOKUP;
      tag_q           <= '0;
      match_q         <= '0;
      valid_q         <= '0;
      ptr_q           <= '0;
      flush_idx_q     <= '0;
      occ_q           <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_hit_q       <= 1'b0;
      rsp_index_q     <= '0;
      rsp_alloc_q     <= 1'b0;
      rsp_evict_q     <= 1'b0;
      rsp_evict_tag_q <= '0;
    end else begin
      valid_q <= valid_d;
      occ_q   <= popcount(valid_d);
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            op_q <= req_op;
            case (req_op)
              OP_LOOKUP, OP_LOOKUP_ALLOC: begin
                tag_q   <= req_tag_i;
                state_q <= ST_MATCH;
              end
              OP_INVAL: begin
                rsp_valid_q     <= 1'b1;
                rsp_hit_q       <= valid_q[req_index_i];
                rsp_index_q     <= req_index_i;
                rsp_alloc_q     <= 1'b0;
                rsp_evict_q     <= 1'b0;
                rsp_evict_tag_q <= '0;
                state_q         <= ST_RESP;
              end
              default: begin
                flush_idx_q <= '0;
                state_q     <= ST_FLUSH;
              end
            endcase
          end
        end
        ST_MATCH: begin
          match_q <= match_d;
          state_q <= ST_DECIDE;
        end
        ST_DECIDE: begin
          rsp_valid_q     <= 1'b1;
          rsp_hit_q       <= enc_hit;
          rsp_index_q     <= enc_hit ? enc_idx : (alloc_now ? alloc_idx : '0);
          rsp_alloc_q     <= alloc_now;
          rsp_evict_q     <= alloc_now && !has_free;
          rsp_evict_tag_q <= (alloc_now && !has_free) ? tags_q[ptr_q] : '0;
          if (alloc_now && !has_free) ptr_q <= ptr_q + 1'b1;
          state_q         <= ST_RESP;
        end
        ST_FLUSH: begin
          flush_idx_q <= flush_idx_q + 1'b1;
          if (flush_idx_q == IDX_W'(NUM_ENT - 1)) begin
            ptr_q           <= '0;
            rsp_valid_q     <= 1'b1;
            rsp_hit_q       <= 1'b0;
            rsp_index_q     <= '0;
            rsp_alloc_q     <= 1'b0;
            rsp_evict_q     <= 1'b0;
            rsp_evict_tag_q <= '0;
            state_q         <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o     = (state_q == ST_IDLE);
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_hit_o       = rsp_hit_q;
  assign rsp_index_o     = rsp_index_q;
  assign rsp_alloc_o     = rsp_alloc_q;
  assign rsp_evict_o     = rsp_evict_q;
  assign rsp_evict_tag_o = rsp_evict_tag_q;
  assign occupancy_o     = occ_q;
endmodule

// File: doc/sampler_tag_table_ctrl.md
SAMPLER_TAG_TABLE_CTRL -- requirements
Module: sampler_tag_table_ctrl

Interface
REQ-001 SHALL have parameter TAG_W, default 26, tag width in bits; entry count is fixed at 16.
REQ-002 SHALL have port clock_i, input, 1, the single clock; all state is on its rising edge.
REQ-003 SHALL have port reset_i, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req_valid_i, input, 1, request valid.
REQ-005 SHALL have port req_ready_o, output, 1, request accepted when req_valid_i and req_ready_o are both high.
REQ-006 SHALL have port req_op_i, input, 2: 00 lookup, 01 lookup-allocate, 10 invalidate-index, 11 flush.
REQ-007 SHALL have port req_tag_i, input, TAG_W, tag for lookup ops.
REQ-008 SHALL have port req_index_i, input, 4, entry index for invalidate-index.
REQ-009 SHALL have port rsp_valid_o, output, 1, response valid.
REQ-010 SHALL have port rsp_ready_i, input, 1, response consumed when rsp_valid_o and rsp_ready_i are both high.
REQ-011 SHALL have port rsp_hit_o, output, 1: lookup found the tag, or invalidate targeted a valid entry.
REQ-012 SHALL have port rsp_index_o, output, 4: hit, allocated or invalidated entry index.
REQ-013 SHALL have port rsp_alloc_o, output, 1: a new entry was written.
REQ-014 SHALL have port rsp_evict_o, output, 1: the allocation displaced a valid entry.
REQ-015 SHALL have port rsp_evict_tag_o, output, TAG_W, tag of the displaced entry.
REQ-016 SHALL have port occupancy_o, output, 5, count of valid entries, 0..16.

Function
REQ-017 SHALL hold 16 entries, each a valid bit plus TAG_W tag, plus a 4-bit round-robin victim pointer.
REQ-018 SHALL use FSM states IDLE, MATCH, DECIDE, RESP and FLUSH; req_ready_o is high only in IDLE, so at most one request is outstanding.
REQ-019 SHALL, on a lookup or lookup-allocate accept in IDLE, register the tag and go to MATCH, where it registers 16 match bits (valid AND tag-equal) and goes to DECIDE.
REQ-020 SHALL, in DECIDE, encode the match bits to an index; any set bit means a hit, which reports that index with rsp_alloc_o=0 and leaves the table unchanged.
REQ-021 SHALL, on a lookup miss, report rsp_hit_o=0 and rsp_index_o=0 with no table change.
REQ-022 SHALL, on a lookup-allocate miss, write the lowest-index invalid entry if one exists (rsp_evict_o=0); when full, it overwrites the entry at the victim pointer, sets rsp_evict_o=1 with the old tag, and advances the pointer modulo 16 (15 wraps to 0).
REQ-023 SHALL make the first rsp_valid_o cycle exactly 3 cycles after the accept cycle for lookup ops.
REQ-024 SHALL execute invalidate-index by clearing that valid bit and going to RESP the next cycle; rsp_hit_o reflects the prior valid bit, and invalidating an invalid entry is a no-op.
REQ-025 SHALL execute flush by clearing one entry per cycle, index 0..15, in FLUSH, then reset the victim pointer to 0 and respond in RESP with all flags 0.
REQ-026 SHALL hold all rsp_* outputs stable in RESP while rsp_ready_i is low, and return to IDLE on the handshake cycle.
REQ-027 SHALL never allocate a tag already present, so at most one match bit is ever set.
REQ-028 SHALL keep occupancy_o equal to the popcount of the valid bits, updated the cycle after each write or clear; it saturates naturally at 16.
REQ-029 SHALL ignore req_* inputs outside IDLE.

Reset
REQ-030 SHALL, on reset_i, immediately clear all valid bits, the victim pointer, occupancy_o, rsp_valid_o, rsp_hit_o, rsp_alloc_o and rsp_evict_o, set rsp_index_o and rsp_evict_tag_o to 0, and return to IDLE with req_ready_o=1 after release.
REQ-031 SHALL abandon any request that is in flight, including a partial flush, when reset is asserted mid-operation, and SHALL produce no response for it.
REQ-032 SHALL NOT require tag storage to be reset; stored tags are don't-care while the entry is invalid.

Structure
REQ-033 SHALL take the op encodings, the FSM state type and the 16-entry/4-bit-index constants from the shared sampler package.
REQ-034 SHALL instantiate tag_match_encoder_4b as its single sub-module for the one-hot to index encoding of the registered match bits.

Verification
REQ-035 SHALL be checked with: reset, then lookup-allocate tags 0x10..0x1F -> indices 0..15, rsp_alloc_o=1, rsp_evict_o=0, occupancy_o=16.
REQ-036 SHALL be checked with: on the full table, lookup tag 0x15 -> rsp_hit_o=1, rsp_index_o=5, response 3 cycles after accept; then lookup 0x99 -> rsp_hit_o=0, no change.
REQ-037 SHALL be checked with: on the full table, 17 lookup-allocates of new tags -> victims 0,1,...,15,0 in order; the first eviction reports rsp_evict_tag_o=0x10, and the pointer wraps.
REQ-038 SHALL be checked with: invalidate index 7, then lookup-allocate 0x200 -> rsp_index_o=7, rsp_evict_o=0, occupancy_o returns to 16.
REQ-039 SHALL be checked with: rsp_ready_i held low for 5 cycles -> rsp_* stable, req_ready_o=0 throughout.
REQ-040 SHALL be checked with: flush, reset_i asserted on the 8th flush cycle -> occupancy_o=0, no response, req_ready_o=1 after release.
